// File: rtl/tone_envelope_pwm.sv
// Speaker output stage: ADSR-style envelope on the note gate, applied to the square-wave tone via PWM.
// Optional macro TONE_ENVELOPE_DIFF_EN adds a complementary speaker_n pin for bridge-tied piezo drive.
module tone_envelope_pwm #(
    parameter logic [7:0]  ATTACK_STEP   = 8'd16,
    parameter logic [7:0]  SUSTAIN_LEVEL = 8'd160,
    parameter logic [15:0] TICK_DIV      = 16'd25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tone_in,
    input  logic       note_on,
    output logic       speaker,
`ifdef TONE_ENVELOPE_DIFF_EN
    output logic       speaker_n,
`endif
    output logic [7:0] env_level,
    output logic       env_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t      state;
    logic        tone_q;
    logic        gate_q;
    logic        gate_d;
    logic [15:0] tick_cnt;
    logic [7:0]  pwm_cnt;
    logic        tick;
    logic        rise;
    logic        fall;
    logic [8:0]  att_sum;
    logic [8:0]  dec_val;
    logic        spk_next;

    assign tick     = (tick_cnt == TICK_DIV - 16'd1);
    assign rise     = gate_q & ~gate_d;
    assign fall     = ~gate_q & gate_d;
    assign att_sum  = {1'b0, env_level} + {1'b0, ATTACK_STEP};
    assign dec_val  = (env_level == 8'd0) ? 9'd0 : ({1'b0, env_level} - 9'd1);
    assign spk_next = tone_q & (pwm_cnt < env_level);

    // Prescaler and PWM counter free-run; note events never restart them.
    always_ff @(posedge clk) begin
        if (rst) begin
            tone_q   <= 1'b0;
            gate_q   <= 1'b0;
            gate_d   <= 1'b0;
            tick_cnt <= 16'd0;
            pwm_cnt  <= 8'd0;
        end else begin
            tone_q   <= tone_in;
            gate_q   <= note_on;
            gate_d   <= gate_q;
            tick_cnt <= tick ? 16'd0 : (tick_cnt + 16'd1);
            pwm_cnt  <= pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            env_level <= 8'd0;
            env_busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    env_level <= 8'd0;
                    if (rise) begin
                        state    <= S_ATTACK;
                        env_busy <= 1'b1;
                    end
                end
                S_ATTACK: begin
                    if (fall) begin
                        state <= S_RELEASE;
                    end else if (tick) begin
                        if (att_sum >= 9'd255) begin
                            env_level <= 8'd255;
                            state     <= S_DECAY;
                        end else begin
                            env_level <= att_sum[7:0];
                        end
                    end
                end
                S_DECAY: begin
                    if (fall) begin
                        state <= S_RELEASE;
                    end else if (tick) begin
                        if (SUSTAIN_LEVEL == 8'd255) begin
                            state <= S_SUSTAIN;
                        end else if (dec_val <= {1'b0, SUSTAIN_LEVEL}) begin
                            env_level <= SUSTAIN_LEVEL;
                            state     <= S_SUSTAIN;
                        end else begin
                            env_level <= dec_val[7:0];
                        end
                    end
                end
                S_SUSTAIN: begin
                    if (fall) begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Retrigger keeps the current level so the new attack has no click.
                    if (rise) begin
                        state <= S_ATTACK;
                    end else if (tick) begin
                        env_level <= dec_val[7:0];
                        if (dec_val == 9'd0) begin
                            state    <= S_IDLE;
                            env_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    env_level <= 8'd0;
                    env_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            speaker   <= 1'b0;
`ifdef TONE_ENVELOPE_DIFF_EN
            speaker_n <= 1'b0;
`endif
        end else begin
            speaker   <= spk_next;
`ifdef TONE_ENVELOPE_DIFF_EN
            speaker_n <= (env_level != 8'd0) ? ~spk_next : 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_tone_envelope_pwm.sv
// Bench for tone_envelope_pwm: scoreboard against a cycle-count based envelope model,
// plus directed envelope-shape and PWM-duty checks.
module tb_tone_envelope_pwm;

    localparam logic [7:0]  A_STEP = 8'd64;
    localparam logic [7:0]  S_LVL  = 8'd128;
    localparam logic [15:0] T_DIV  = 16'd4;

    localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tone_in = 1'b0;
    logic       note_on = 1'b0;
    logic       speaker;
    logic [7:0] env_level;
    logic       env_busy;
`ifdef TONE_ENVELOPE_DIFF_EN
    logic       speaker_n;
`endif

    tone_envelope_pwm #(
        .ATTACK_STEP  (A_STEP),
        .SUSTAIN_LEVEL(S_LVL),
        .TICK_DIV     (T_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tone_in  (tone_in),
        .note_on  (note_on),
        .speaker  (speaker),
`ifdef TONE_ENVELOPE_DIFF_EN
        .speaker_n(speaker_n),
`endif
        .env_level(env_level),
        .env_busy (env_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int env;
        int busy;
        int spk;
        int spkn;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit n, input bit t);
        @(posedge clk);
        #1;
        rst = r;
        note_on = n;
        tone_in = t;
    endtask

    task automatic waitChange(output int val);
        int prev;
        prev = env_level;
        val = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (int'(env_level) != prev) begin
                val = env_level;
                return;
            end
        end
        total++;
        bad++;
        $display("[TB] FAIL env_change_timeout: got %0d, want a change", prev);
    endtask

    task automatic waitFor(input int level, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(env_level) == level) return;
        end
        total++;
        bad++;
        $display("[TB] FAIL env_wait_timeout: got %0d, want %0d", env_level, level);
    endtask

    // Reference model: envelope rules applied with plain integer arithmetic,
    // counters derived from the number of clocks since reset.
    int m_tq, m_gq, m_gd, m_env, m_phase, m_cyc;
    always @(posedge clk) begin : model
        exp_t e;
        bit rise, fall, tick;
        int spk, spkn;
        if (rst) begin
            m_tq = 0; m_gq = 0; m_gd = 0; m_env = 0; m_phase = P_IDLE; m_cyc = 0;
            spk = 0; spkn = 0;
        end else begin
            spk  = (m_tq != 0 && (m_cyc % 256) < m_env) ? 1 : 0;
            spkn = (m_env != 0 && spk == 0) ? 1 : 0;
            rise = (m_gq == 1 && m_gd == 0);
            fall = (m_gq == 0 && m_gd == 1);
            tick = ((m_cyc % int'(T_DIV)) == int'(T_DIV) - 1);
            if (rise && (m_phase == P_IDLE || m_phase == P_REL)) begin
                m_phase = P_ATT;
            end else if (fall && (m_phase == P_ATT || m_phase == P_DEC || m_phase == P_SUS)) begin
                m_phase = P_REL;
            end else if (tick) begin
                case (m_phase)
                    P_ATT: begin
                        m_env = (m_env + int'(A_STEP) > 255) ? 255 : m_env + int'(A_STEP);
                        if (m_env == 255) m_phase = P_DEC;
                    end
                    P_DEC: begin
                        m_env = (m_env - 1 < int'(S_LVL)) ? int'(S_LVL) : m_env - 1;
                        if (m_env == int'(S_LVL)) m_phase = P_SUS;
                    end
                    P_REL: begin
                        m_env = (m_env > 0) ? m_env - 1 : 0;
                        if (m_env == 0) m_phase = P_IDLE;
                    end
                    default: ;
                endcase
            end
            m_tq = tone_in;
            m_gd = m_gq;
            m_gq = note_on;
            m_cyc++;
        end
        e.env  = m_env;
        e.busy = (m_phase != P_IDLE) ? 1 : 0;
        e.spk  = spk;
        e.spkn = spkn;
        sbq.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("sb_env_level", env_level, e.env);
            checkOutput("sb_env_busy", env_busy, e.busy);
            checkOutput("sb_speaker", speaker, e.spk);
`ifdef TONE_ENVELOPE_DIFF_EN
            checkOutput("sb_speaker_n", speaker_n, e.spkn);
`endif
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v, prevv, cnt, hi, len;
        bit n, r;
        int att_exp[4];
        int retrig_exp[3];
        att_exp    = '{64, 128, 192, 255};
        retrig_exp = '{164, 228, 255};

        rst = 1'b1;
        tone_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_env", env_level, 0);
        checkOutput("reset_busy", env_busy, 0);
        checkOutput("reset_speaker", speaker, 0);

        // Note on: busy two cycles after the gate edge, then attack and decay shape.
        applyStimulus(0, 1, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_one_cycle", env_busy, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_two_cycles", env_busy, 1);
        for (int k = 0; k < 4; k++) begin
            waitChange(v);
            checkOutput("attack_step", v, att_exp[k]);
        end
        prevv = 255;
        cnt = 0;
        while (prevv > 128 && cnt < 200) begin
            waitChange(v);
            checkOutput("decay_step", v, prevv - 1);
            prevv = v;
            cnt++;
        end
        checkOutput("ticks_to_sustain", cnt + 4, 131);
        repeat (40) @(negedge clk);
        checkOutput("sustain_hold", env_level, 128);
        checkOutput("sustain_busy", env_busy, 1);

        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(speaker);
        end
        checkOutput("duty_128", hi, 128);

        tone_in = 1'b0;
        repeat (4) @(negedge clk);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(speaker);
        end
        checkOutput("duty_tone_low", hi, 0);
        tone_in = 1'b1;

        // Release from sustain to idle.
        note_on = 1'b0;
        prevv = 128;
        cnt = 0;
        while (prevv > 0 && cnt < 200) begin
            waitChange(v);
            prevv = v;
            cnt++;
        end
        checkOutput("release_ticks", cnt, 128);
        checkOutput("busy_after_release", env_busy, 0);
        repeat (20) @(negedge clk);
        checkOutput("idle_env", env_level, 0);
        checkOutput("idle_busy", env_busy, 0);

        // Retrigger during release resumes attack from the current level.
        note_on = 1'b1;
        waitFor(255, 100);
        waitFor(128, 1000);
        note_on = 1'b0;
        waitFor(100, 400);
        note_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            waitChange(v);
            checkOutput("retrigger_step", v, retrig_exp[k]);
        end
        waitFor(128, 1000);

        // Reset in sustain aborts with no fade.
        rst = 1'b1;
        note_on = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midnote_reset_env", env_level, 0);
        checkOutput("midnote_reset_speaker", speaker, 0);
        checkOutput("midnote_reset_busy", env_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("post_reset_idle_env", env_level, 0);
        checkOutput("post_reset_idle_busy", env_busy, 0);

        // Gate drop during attack releases from the attack level.
        note_on = 1'b1;
        waitFor(128, 40);
        note_on = 1'b0;
        waitChange(v);
        checkOutput("attack_drop_step", v, 127);
        checkOutput("attack_drop_busy", env_busy, 1);
        waitFor(0, 1000);

        // Randomised gate/tone/reset traffic, checked by the scoreboard.
        for (int seg = 0; seg < 40; seg++) begin
            n = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 19) == 0);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(400, 900))
                                              : int'($urandom_range(1, 60));
            for (int i = 0; i < len; i++) begin
                applyStimulus(r && (i < 2), n, 1'($urandom_range(0, 1)));
            end
        end

        applyStimulus(0, 0, 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
